// File: rtl/pulse_sync_pkg.sv
// Shared types and defaults for the pulse pacer / toggle synchroniser pair.
// Holds the pacer FSM encoding and the parameter defaults used by every file.
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FIRE      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } pacer_state_e;

    localparam int unsigned CNT_W_DEF     = 4;
    localparam int unsigned GUARD_CYC_DEF = 4;

    // Width needed to hold GUARD_CYC-1; never narrower than one bit.
    function automatic int unsigned guard_w(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/pulse_event_pacer_if.sv
// Event-in / pulse-out bundle between the pacer and its environment.
// The master side drives events, busy and clear; the slave side is the pacer.
interface pulse_event_pacer_if #(
    parameter int unsigned CNT_W = pulse_sync_pkg::CNT_W_DEF
) ();

    logic             ev_i;
    logic             busy_i;
    logic             clr_ovf_i;
    logic             pulse_o;
    logic [CNT_W-1:0] pending_o;
    logic             ovf_o;
    logic             idle_o;

    modport master (
        output ev_i,
        output busy_i,
        output clr_ovf_i,
        input  pulse_o,
        input  pending_o,
        input  ovf_o,
        input  idle_o
    );

    modport slave (
        input  ev_i,
        input  busy_i,
        input  clr_ovf_i,
        output pulse_o,
        output pending_o,
        output ovf_o,
        output idle_o
    );

endinterface

// File: rtl/pulse_event_pacer_sat_updown_cnt.sv
// Saturating up/down counter; 1-cycle update; an increment at all-ones with no
// decrement is refused and reported on drop in the same cycle.
module sat_updown_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_a,
    input  logic         rst_a,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         drop
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign full = &cnt_q;
    assign drop = inc & ~dec & full;
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            if (!full) begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec && !inc) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_event_pacer.sv
// Queues bursty event strobes and replays them as isolated one-cycle pulses.
// Latency: event at edge N gives pulse in cycle N+1..N+2; waits on busy_i.
module pulse_event_pacer
    import pulse_sync_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned GUARD_CYC = GUARD_CYC_DEF
) (
    input  logic               clk_a,
    input  logic               rst_a,
    pulse_event_pacer_if.slave bus
);

    localparam int unsigned     GW         = guard_w(GUARD_CYC);
    localparam logic [GW-1:0]   GUARD_LOAD = GW'(GUARD_CYC - 1);

    pacer_state_e     state_q;
    pacer_state_e     state_d;
    logic [GW-1:0]    guard_q;
    logic [GW-1:0]    guard_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             fire;
    logic [CNT_W-1:0] pending;
    logic             cnt_full;
    logic             cnt_drop;

    assign fire = (state_q == ST_FIRE);

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_pending (
        .clk_a (clk_a),
        .rst_a (rst_a),
        .inc   (bus.ev_i),
        .dec   (fire),
        .cnt   (pending),
        .full  (cnt_full),
        .drop  (cnt_drop)
    );

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            ST_IDLE: begin
                if ((pending != '0) && !bus.busy_i) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT_BUSY;
                guard_d = GUARD_LOAD;
            end
            ST_WAIT_BUSY: begin
                // A synchroniser that never answers must not stall the queue.
                if (bus.busy_i) begin
                    state_d = ST_WAIT_IDLE;
                end else if (guard_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (!bus.busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pulse_d = (state_d == ST_FIRE);
        ovf_d   = ovf_q;
        // A fresh drop outranks a clear arriving in the same cycle.
        if (cnt_drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            state_q <= ST_IDLE;
            guard_q <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.pulse_o   = pulse_q;
    assign bus.pending_o = pending;
    assign bus.ovf_o     = ovf_q;
    assign bus.idle_o    = (state_q == ST_IDLE) && (pending == '0);

endmodule

// File: tb/tb_pulse_event_pacer.sv
// Bench for pulse_event_pacer: vector table, burst with busy model,
// overflow on a narrow instance, and a toggle-synchroniser round trip.
module tb_pulse_event_pacer;
    import pulse_sync_pkg::*;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    logic rst_a;
    logic busy_drv;
    logic integ;

    always #5  clk_a = ~clk_a;
    always #10 clk_b = ~clk_b;

    pulse_event_pacer_if #(.CNT_W(4)) bus ();
    pulse_event_pacer_if #(.CNT_W(2)) bus2 ();

    pulse_event_pacer #(.CNT_W(4), .GUARD_CYC(4)) dut (
        .clk_a (clk_a),
        .rst_a (rst_a),
        .bus   (bus)
    );

    pulse_event_pacer #(.CNT_W(2), .GUARD_CYC(4)) dut2 (
        .clk_a (clk_a),
        .rst_a (rst_a),
        .bus   (bus2)
    );

    // Toggle synchroniser model: clk_b runs at half the rate of clk_a.
    logic tog_a  = 1'b0;
    logic ack_s1 = 1'b0;
    logic ack_s2 = 1'b0;
    logic b_s1   = 1'b0;
    logic b_s2   = 1'b0;
    logic b_s3   = 1'b0;
    logic sync_busy;
    logic pulse_b;

    always @(posedge clk_a) begin
        tog_a  <= tog_a ^ (bus.pulse_o === 1'b1);
        ack_s1 <= b_s2;
        ack_s2 <= ack_s1;
    end

    always @(posedge clk_b) begin
        b_s1 <= tog_a;
        b_s2 <= b_s1;
        b_s3 <= b_s2;
    end

    assign sync_busy  = tog_a ^ ack_s2;
    assign pulse_b    = b_s2 ^ b_s3;
    assign bus.busy_i = integ ? sync_busy : busy_drv;

    int checks = 0;
    int errors = 0;
    int pb_cnt = 0;
    int iq[$];

    always @(posedge clk_b) begin
        if (integ && pulse_b) begin
            pb_cnt <= pb_cnt + 1;
            if (iq.size() > 0) void'(iq.pop_front());
        end
    end

    typedef struct {
        logic       rst;
        logic       ev;
        logic       busy;
        logic       e_pulse;
        logic [3:0] e_pend;
        logic       e_ovf;
        logic       e_idle;
    } vec_t;

    vec_t vt[29];
    vec_t exp_q[$];
    int   bq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    initial begin
        vec_t e;
        int   bcnt;
        int   last_busy;
        int   pulses;
        int   peak;
        int   viol;
        logic prev_pulse;

        //           rst   ev    busy  pulse pend  ovf   idle
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vt[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[26] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0};
        vt[27] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
        vt[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};

        integ          = 1'b0;
        busy_drv       = 1'b0;
        bus.clr_ovf_i  = 1'b0;
        bus.ev_i       = 1'b0;
        bus2.ev_i      = 1'b0;
        bus2.busy_i    = 1'b1;
        bus2.clr_ovf_i = 1'b0;
        rst_a          = 1'b1;

        for (int i = 0; i < 29; i++) begin
            rst_a    = vt[i].rst;
            bus.ev_i = vt[i].ev;
            busy_drv = vt[i].busy;
            exp_q.push_back(vt[i]);
            step();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d pulse", i), int'(bus.pulse_o), int'(e.e_pulse));
            chk($sformatf("vec%0d pending", i), int'(bus.pending_o), int'(e.e_pend));
            chk($sformatf("vec%0d ovf", i), int'(bus.ovf_o), int'(e.e_ovf));
            chk($sformatf("vec%0d idle", i), int'(bus.idle_o), int'(e.e_idle));
        end

        // Burst of 5 with busy rising 1 cycle after each pulse for 6 cycles.
        bcnt       = 0;
        last_busy  = -100;
        pulses     = 0;
        peak       = 0;
        prev_pulse = 1'b0;
        for (int c = 0; c < 90; c++) begin
            bus.ev_i = (c < 5);
            if (c < 5) bq.push_back(c);
            step();
            if (int'(bus.pending_o) > peak) peak = int'(bus.pending_o);
            if (bcnt > 0) begin
                busy_drv = 1'b1;
                bcnt--;
            end else begin
                busy_drv = 1'b0;
            end
            if (busy_drv) last_busy = c;
            if (bus.pulse_o) begin
                pulses++;
                if (bq.size() > 0) void'(bq.pop_front());
                chk($sformatf("burst pulse%0d after busy fall", pulses),
                    int'((c - last_busy) >= 2 && !prev_pulse), 1);
                bcnt = 6;
            end
            prev_pulse = bus.pulse_o;
        end
        bus.ev_i = 1'b0;
        chk("burst pending peak", peak, 4);
        chk("burst pulse count", pulses, 5);
        chk("burst scoreboard left", bq.size(), 0);
        chk("burst final pending", int'(bus.pending_o), 0);
        chk("burst final idle", int'(bus.idle_o), 1);

        // Overflow on the 2-bit instance with busy held high.
        for (int k = 1; k <= 7; k++) begin
            bus2.ev_i      = (k <= 5);
            bus2.clr_ovf_i = (k == 5) || (k == 6);
            step();
            chk($sformatf("ovf step%0d pending", k), int'(bus2.pending_o), (k < 3) ? k : 3);
            chk($sformatf("ovf step%0d ovf", k), int'(bus2.ovf_o), (k >= 4 && k <= 5) ? 1 : 0);
            chk($sformatf("ovf step%0d pulse", k), int'(bus2.pulse_o), 0);
        end
        bus2.ev_i      = 1'b0;
        bus2.clr_ovf_i = 1'b0;

        // Round trip through the synchroniser model.
        for (int w = 0; w < 20 && sync_busy; w++) step();
        chk("sync model quiet", int'(sync_busy), 0);
        integ = 1'b1;
        viol  = 0;
        for (int n = 0; n < 8; n++) begin
            int gap;
            bus.ev_i = 1'b1;
            iq.push_back(n);
            step();
            if (bus.pulse_o && sync_busy) viol++;
            bus.ev_i = 1'b0;
            gap = $urandom_range(0, 15);
            for (int g = 0; g < gap; g++) begin
                step();
                if (bus.pulse_o && sync_busy) viol++;
            end
        end
        for (int w = 0; w < 600 && !(pb_cnt == 8 && bus.idle_o && !sync_busy); w++) begin
            step();
            if (bus.pulse_o && sync_busy) viol++;
        end
        repeat (8) step();
        chk("integ pulseB count", pb_cnt, 8);
        chk("integ scoreboard left", iq.size(), 0);
        chk("integ pulse while busy", viol, 0);
        chk("integ final idle", int'(bus.idle_o), 1);
        chk("integ final ovf", int'(bus.ovf_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
